// File: rtl/multi_seq_scaler.sv
// multi_seq_scaler: accepts one operand via valid/grant, then streams the
// operand multiplied by each entry of a runtime-writable coefficient table,
// one full-width unsigned product per beat, with ready backpressure.
module multi_seq_scaler #(
    parameter int unsigned     W         = 8,
    parameter int unsigned     CW        = 4,
    parameter int unsigned     N         = 4,
    parameter int unsigned     OW        = W + CW,
    parameter logic [N*CW-1:0] COEF_INIT = {4'd8, 4'd7, 4'd3, 4'd1}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         d,
    input  logic                 in_valid,
    input  logic [$clog2(N):0]   seq_len,
    output logic                 input_grant,
    input  logic                 coef_we,
    input  logic [$clog2(N)-1:0] coef_addr,
    input  logic [CW-1:0]        coef_wdata,
    output logic [OW-1:0]        out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [W-1:0]  opnd;
    logic [LW-1:0] len;
    logic [CW-1:0] coef [N];

    logic [LW-1:0] eff_len;
    logic          beat;
    logic          accept;
    logic [AW-1:0] next_idx;

    // Handshake decode, effective sequence length and next table index
    always_comb begin
        eff_len     = seq_len;
        if (seq_len == '0 || seq_len > LW'(N)) begin
            eff_len = LW'(N);
        end
        beat        = out_valid && out_ready;
        input_grant = (state == IDLE) || (beat && out_last);
        accept      = in_valid && input_grant;
        next_idx    = out_idx + AW'(1);
    end

    // Sequencer FSM, operand/length latches, output beat register and table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opnd      <= '0;
            len       <= LW'(N);
            out       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                coef[i] <= COEF_INIT[i*CW +: CW];
            end
        end else begin
            // Table write; products below read the pre-write value this edge
            if (coef_we && (LW'(coef_addr) < LW'(N))) begin
                coef[coef_addr] <= coef_wdata;
            end

            if (accept) begin
                opnd      <= d;
                len       <= eff_len;
                out       <= OW'(d) * OW'(coef[0]);
                out_idx   <= '0;
                out_valid <= 1'b1;
                out_last  <= (eff_len == LW'(1));
                state     <= RUN;
            end else if (beat) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= IDLE;
                end else begin
                    out_idx  <= next_idx;
                    out      <= OW'(opnd) * OW'(coef[next_idx]);
                    out_last <= (LW'(next_idx) == len - LW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_seq_scaler.sv
// Directed self-checking bench for multi_seq_scaler.
module tb_multi_seq_scaler;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned OW = W + CW;

    logic          clk;
    logic          rst;
    logic [W-1:0]  d;
    logic          in_valid;
    logic [2:0]    seq_len;
    logic          input_grant;
    logic          coef_we;
    logic [1:0]    coef_addr;
    logic [CW-1:0] coef_wdata;
    logic [OW-1:0] out;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_idx;
    logic          out_last;

    int checks;
    int failures;

    multi_seq_scaler #(
        .W (W),
        .CW(CW),
        .N (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .in_valid   (in_valid),
        .seq_len    (seq_len),
        .input_grant(input_grant),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int e_out, input int e_idx, input int e_last);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out"},   32'(out),       32'(e_out));
        chk({tag, ".idx"},   32'(out_idx),   32'(e_idx));
        chk({tag, ".last"},  32'(out_last),  32'(e_last));
    endtask

    int exp255 [4];

    initial begin
        checks     = 0;
        failures   = 0;
        exp255[0]  = 255;
        exp255[1]  = 765;
        exp255[2]  = 1785;
        exp255[3]  = 2040;

        rst        = 1'b1;
        d          = '0;
        in_valid   = 1'b0;
        seq_len    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        out_ready  = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst.out",   32'(out),         32'd0);
        chk("rst.valid", 32'(out_valid),   32'd0);
        chk("rst.idx",   32'(out_idx),     32'd0);
        chk("rst.last",  32'(out_last),    32'd0);
        chk("rst.grant", 32'(input_grant), 32'd1);
        rst = 1'b0;
        tick();

        // Default table, d=10, seq_len=0
        d = 8'd10; seq_len = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t1.b0", 10, 0, 0);
        chk("t1.grant0", 32'(input_grant), 32'd0);
        tick(); chk_beat("t1.b1", 30, 1, 0);
        tick(); chk_beat("t1.b2", 70, 2, 0);
        tick(); chk_beat("t1.b3", 80, 3, 1);
        chk("t1.grant3", 32'(input_grant), 32'd1);
        tick();
        chk("t1.idle.valid", 32'(out_valid),   32'd0);
        chk("t1.idle.grant", 32'(input_grant), 32'd1);

        // Back-to-back max operand with in_valid held
        d = 8'd255; in_valid = 1'b1;
        tick();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 4; i++) begin
                chk_beat($sformatf("t2.r%0d.b%0d", rep, i), exp255[i], i, (i == 3) ? 1 : 0);
                if (rep == 1 && i == 3) in_valid = 1'b0;
                tick();
            end
        end
        chk("t2.idle.valid", 32'(out_valid), 32'd0);

        // Backpressure on the second beat
        d = 8'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t3.b0", 5, 0, 0);
        tick();
        chk_beat("t3.b1", 15, 1, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_beat($sformatf("t3.stall%0d", i), 15, 1, 0);
            chk($sformatf("t3.stall%0d.grant", i), 32'(input_grant), 32'd0);
        end
        out_ready = 1'b1;
        tick(); chk_beat("t3.b2", 35, 2, 0);
        tick(); chk_beat("t3.b3", 40, 3, 1);
        tick();
        chk("t3.idle.valid", 32'(out_valid), 32'd0);

        // Coefficient write coinciding with the idx-2 load
        d = 8'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t4.b0", 4, 0, 0);
        tick();
        chk_beat("t4.b1", 12, 1, 0);
        coef_we = 1'b1; coef_addr = 2'd2; coef_wdata = 4'd15;
        tick();
        coef_we = 1'b0;
        chk_beat("t4.b2.old", 28, 2, 0);
        tick(); chk_beat("t4.b3", 32, 3, 1);
        tick();
        d = 8'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t4n.b0", 4, 0, 0);
        tick(); chk_beat("t4n.b1", 12, 1, 0);
        tick(); chk_beat("t4n.b2", 60, 2, 0);
        tick(); chk_beat("t4n.b3", 32, 3, 1);
        tick();

        // Sequence length variants (table now 1,3,15,8)
        d = 8'd9; seq_len = 3'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t5a.b0", 9, 0, 0);
        tick(); chk_beat("t5a.b1", 27, 1, 1);
        tick();
        chk("t5a.idle.valid", 32'(out_valid), 32'd0);

        seq_len = 3'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t5b.b0", 9, 0, 1);
        tick();
        chk("t5b.idle.valid", 32'(out_valid), 32'd0);

        seq_len = 3'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t5c.b0", 9, 0, 0);
        tick(); chk_beat("t5c.b1", 27, 1, 0);
        tick(); chk_beat("t5c.b2", 135, 2, 0);
        tick(); chk_beat("t5c.b3", 72, 3, 1);
        tick();
        chk("t5c.idle.valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-sequence restores the table
        d = 8'd2; seq_len = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t6.b0", 2, 0, 0);
        tick();
        chk_beat("t6.b1", 6, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.arst.out",   32'(out),       32'd0);
        chk("t6.arst.valid", 32'(out_valid), 32'd0);
        chk("t6.arst.last",  32'(out_last),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6.post.valid", 32'(out_valid), 32'd0);
        d = 8'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("t6n.b0", 2, 0, 0);
        tick(); chk_beat("t6n.b1", 6, 1, 0);
        tick(); chk_beat("t6n.b2", 14, 2, 0);
        tick(); chk_beat("t6n.b3", 16, 3, 1);
        tick();
        chk("t6n.idle.valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_seq_scaler.md
Name: multi_seq_scaler

Overview:
- Parametrised successor to the fixed x1/x3/x7/x8 sequential multiplier.
- Accepts one operand through a valid/grant handshake, then emits that operand multiplied by each entry of a runtime-writable coefficient table, one product per output beat.
- The output side has ready backpressure; sequence length is selectable per operand.
- Sits between a sample source and a downstream accumulate/filter stage.

Parameters:
- W, 8, operand width.
- CW, 4, coefficient width (unsigned).
- N, 4, coefficient table depth and maximum sequence length (2..16).
- OW, W+CW, output width; products are unsigned and never truncated.
- COEF_INIT, {4'd8,4'd7,4'd3,4'd1}, packed reset table (entry 0 in LSBs; default sequence x1, x3, x7, x8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- d  in  W  operand.
- in_valid  in  1  operand valid.
- seq_len  in  $clog2(N)+1  number of products for this operand; sampled at accept; 0 or >N treated as N.
- input_grant  out  1  operand accepted when in_valid && input_grant at a clock edge.
- coef_we  in  1  coefficient table write enable.
- coef_addr  in  $clog2(N)  table index.
- coef_wdata  in  CW  coefficient value.
- out  out  OW  product, registered.
- out_valid  out  1  out holds a valid product.
- out_ready  in  1  downstream accepts out when out_valid && out_ready.
- out_idx  out  $clog2(N)  table index that produced out.
- out_last  out  1  marks the final product of the current operand.

Behaviour:
- Single clock. Reset is asynchronous and active-high on rst; clock port clk, reset port rst.
- Reset values:
  - out, out_valid, out_idx, out_last = 0.
  - FSM = IDLE; input_grant = 1 once IDLE.
  - Operand latch = 0; length register = N.
  - Table reloads COEF_INIT.
- Reset mid-sequence aborts the sequence; no further beats for that operand.
- FSM has two states, IDLE and RUN.
- input_grant is combinational: (state==IDLE) || (out_valid && out_ready && out_last).
- Accept (in_valid && input_grant):
  - latch d and the effective length L;
  - load out = d*coef[0], out_idx = 0, out_valid = 1, out_last = (L==1);
  - go to RUN.
  - Latency from accept edge to first valid beat is 1 cycle, registered.
- RUN, beat accepted and not last: out_idx+1, out = latched*coef[out_idx+1], out_last = (out_idx+1 == L-1).
- RUN, out_valid && !out_ready: out, out_idx and out_last hold stable. Coefficient writes do not alter a product already in out.
- RUN, last beat accepted:
  - with a new accept in the same edge, load that operand's first product (back-to-back, zero bubble, stay in RUN);
  - otherwise out_valid = 0 and go to IDLE.
- Throughput is L beats per operand when out_ready stays high.
- Coefficient table:
  - writes take effect at the edge where coef_we is high, in any state;
  - a product loaded at the same edge as a write to its index uses the old value (read-before-write);
  - products loaded at later edges use the new value.
- Arithmetic: out = zero-extend(operand) * zero-extend(coef), full OW bits.
  - Maximum value is (2^W-1)*(2^CW-1), which fits in OW.
  - Coefficient 0 yields out = 0 and still counts as a beat.
- in_valid while busy (input_grant = 0): the operand is ignored; the source must hold it.
- d changing during RUN has no effect, because the operand is latched.

Test Plan:
- Default table, d=10, seq_len=0, out_ready=1 -> out 10, 30, 70, 80 on 4 consecutive cycles starting the cycle after accept; out_idx 0..3; out_last only on 80; input_grant high on the 80 beat.
- d=255, in_valid held high, out_ready=1 -> 255, 765, 1785, 2040 repeating with no gap between sequences; out never exceeds 11 bits.
- d=5, out_ready low 3 cycles during the beat 15 -> out=15 and out_idx=1 stay stable throughout; the sequence then resumes with 35, 40; no beat dropped or duplicated.
- Write coef[2]=15 at the edge that loads idx 2 for d=4 -> that beat outputs 28; the next operand d=4 outputs 4, 12, 60, 32.
- d=9, seq_len=2 -> beats 9 and 27 only, out_last on 27; seq_len=1 -> single beat 9 with out_last=1; seq_len=7 (>N) -> 4 beats.
- Assert rst asynchronously mid-sequence after 2 beats -> out, out_valid and out_last drop to 0 immediately; table restored (a previously written coef[2]=15 reverts to 7); next d=2 outputs 2, 6, 14, 16.
